// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX-stage decode and the iterative M-extension unit.
// The master issues ops and flush; the slave reports stall, busy and the result.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, Funct3, op_a, op_b, flush,
    input  busy, stall_req, result_valid, result
  );

  modport slave (
    input  start, Funct3, op_a, op_b, flush,
    output busy, stall_req, result_valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Operands are latched on acceptance; sign fix-up happens in PREP and FIX around the core loop.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input logic                clk,
  input logic                rst_n,
  muldiv_sequencer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Rem    = 3'b110;

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e            state_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q;
  logic              busy_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  // PREP decode: signedness, magnitudes and special cases
  logic            is_div;
  logic            is_rem;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;

  assign is_div   = f3_q[2];
  assign is_rem   = f3_q[1];
  assign a_signed = (f3_q == F3Mulh) || (f3_q == F3Mulhsu) || (f3_q == F3Div) || (f3_q == F3Rem);
  assign b_signed = (f3_q == F3Mulh) || (f3_q == F3Div) || (f3_q == F3Rem);
  assign a_neg    = a_signed & a_q[XLEN-1];
  assign b_neg    = b_signed & b_q[XLEN-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = ((f3_q == F3Div) || (f3_q == F3Rem)) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);

  // CALC step. Multiply: acc = {partial product, remaining multiplier bits}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
  logic [XLEN:0]     div_part;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  assign div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_part - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // FIX: sign correction and word select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    if (is_div) begin
      fix_result = is_rem ? rem_fix : quo_fix;
    end else begin
      fix_result = (f3_q == F3Mul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (bus.start) begin
            f3_q    <= bus.Funct3;
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            busy_q  <= 1'b1;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          if (div_zero) begin
            result_q <= is_rem ? a_q : '1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end else if (div_ovf) begin
            result_q <= is_rem ? '0 : a_q;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end else begin
            a_q     <= a_mag;
            b_q     <= b_mag;
            acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            // Remainder follows the dividend sign; product and quotient follow the sign xor.
            neg_q   <= (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
            cnt_q   <= CntW'(XLEN);
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= is_div ? div_next : mul_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= fix_result;
          busy_q   <= 1'b0;
          valid_q  <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
  assign bus.stall_req    = busy_q | (bus.start & (state_q == StIdle) & ~bus.flush);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table for arithmetic and latency,
// plus hand-written sequences for flush, start collisions and mid-op reset.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // Issues one op with start held for one cycle, scrambles operands after acceptance,
  // then checks latency, result, stall_req profile and the single-cycle valid pulse.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int id);
    int   n;
    logic stall_ok;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    #1;
    check($sformatf("v%0d stall_t0", id), 32'(bus.stall_req), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = a ^ b;
    n = 1;
    stall_ok = 1'b1;
    while (!bus.result_valid && n < 60) begin
      if (!bus.stall_req) stall_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check($sformatf("v%0d latency", id), 32'(n), 32'(lat));
    check($sformatf("v%0d result", id), bus.result, exp);
    check($sformatf("v%0d stall_busy", id), 32'(stall_ok), 32'd1);
    check($sformatf("v%0d stall_done", id), 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d valid_pulse", id), 32'(bus.result_valid), 32'd0);
    check($sformatf("v%0d result_hold", id), bus.result, exp);
  endtask

  logic [31:0] last_result;
  logic        seen_valid;
  logic        seen_busy;
  int          n;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
    vecs[2]  = '{3'b001, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 35};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 35};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       35};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        35};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 2};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        2};
    vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,      2};
    vecs[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};

    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;

    #12;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst valid", 32'(bus.result_valid), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i);
    end
    last_result = vecs[11].exp;

    // Flush at t0+10 of a DIV, with an ignored start at t0+5.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Funct3 = 3'b100;
    bus.op_a   = 32'hFFFF_FFF9;
    bus.op_b   = 32'd2;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k < 10; k++) begin
      bus.start  = (k == 5);
      bus.Funct3 = (k == 5) ? 3'b000 : 3'b100;
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush valid", 32'(bus.result_valid), 32'd0);
    check("flush result", bus.result, last_result);
    seen_valid = 1'b0;
    seen_busy  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.result_valid) seen_valid = 1'b1;
      if (bus.busy) seen_busy = 1'b1;
    end
    check("flush no valid", 32'(seen_valid), 32'd0);
    check("flush no restart", 32'(seen_busy), 32'd0);

    // Flush and start together in IDLE: op must not be accepted.
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd4;
    #1;
    check("flush+start stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush+start busy", 32'(bus.busy), 32'd0);
    check("flush+start result", bus.result, last_result);

    // start held through DONE: ignored there, accepted in the following IDLE cycle.
    bus.start  = 1'b1;
    bus.Funct3 = 3'b101;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    while (!bus.result_valid && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("held start latency", 32'(n), 32'd35);
    check("held start result", bus.result, 32'd14);
    @(negedge clk);
    check("idle after done busy", 32'(bus.busy), 32'd0);
    check("idle after done stall", 32'(bus.stall_req), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check("re-accept busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("cleanup busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of CALC, then a fresh MUL 3x4.
    bus.start  = 1'b1;
    bus.Funct3 = 3'b101;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(bus.busy), 32'd0);
    check("mid rst valid", 32'(bus.result_valid), 32'd0);
    check("mid rst result", bus.result, 32'd0);
    check("mid rst stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 35, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit and its sequencing FSM, placed beside the EX-stage ALU.
- The ALU decode forwards M-extension instructions (Funct7 = 0000001) here.
- The block stalls the pipeline while it iterates, then returns one 32-bit result with a single-cycle valid pulse.
- It handles the signed/unsigned operand fix-up and the RISC-V divide special cases.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN; counter width is clog2(XLEN)+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request for a new M-op; sampled only in IDLE
- Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (multiplicand/dividend)
- op_b  input  XLEN  rs2 value (multiplier/divisor)
- flush  input  1  pipeline flush; aborts any operation
- busy  output  1  high in PREP, CALC and FIX
- stall_req  output  1  combinational: busy | (start & state==IDLE & !flush)
- result_valid  output  1  one-cycle pulse, high in DONE
- result  output  XLEN  final value; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0; result_valid=0; result=0; counter, operand and accumulator registers =0.
- States and transitions:
  - IDLE -> PREP on a clk edge with start=1 and flush=0. At that edge, latch Funct3, op_a and op_b.
  - PREP (1 cycle): form the signed flags and take the operand magnitudes.
    - MULH, DIV, REM: both operands signed. MULHSU: op_a signed only. MUL, MULHU, DIVU, REMU: unsigned magnitudes; MUL low word is sign-agnostic.
    - Divide by zero and signed overflow go PREP -> DONE; all other ops go PREP -> CALC with counter=XLEN.
  - CALC (XLEN cycles):
    - Multiply: shift-add, producing a 2*XLEN-bit product.
    - Divide: restoring shift-subtract, producing quotient and remainder.
    - Counter decrements each cycle; go to FIX when the counter reaches 1 on the current edge.
  - FIX (1 cycle): apply the sign correction and select the result word.
    - Negate the product if the operand signs differ.
    - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
    - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
  - DONE (1 cycle): result_valid=1, then go to IDLE.
- Latency with start accepted at edge t0:
  - Normal op: result_valid high during cycle t0+XLEN+3 (35 for XLEN=32).
  - Special-case op: result_valid high during cycle t0+2.
  - stall_req is high from cycle t0 (combinational) through the FIX cycle; it is low in DONE.
- Special cases, decided in PREP:
  - DIV/DIVU by zero: result = all ones.
  - REM/REMU by zero: result = op_a.
  - DIV of 0x80000000 by 0xFFFFFFFF: result = 0x80000000. REM of the same: result = 0.
- Boundary conditions:
  - start while not IDLE: ignored, with no effect on the running op.
  - flush in any state: go to IDLE at the next edge; result_valid stays 0 and result keeps its old value.
  - flush and start in the same IDLE cycle: flush wins and the op is not accepted.
  - start in DONE: ignored; the op is accepted on the next IDLE cycle.
  - Reset mid-operation: immediate return to the reset values; no result_valid.
  - Operands are latched, so op_a and op_b may change freely after acceptance.
- Arithmetic: all internal subtractions use XLEN+1 bits; magnitude of 0x80000000 is 0x80000000 unsigned; the product accumulator is 2*XLEN bits.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB at t0+35; stall_req high t0..t0+34; one-cycle result_valid.
- MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULH, 7 x -3 -> 0xFFFFFFFF. MULHSU, -1 x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. All at t0+35.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at t0+2. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at t0+2.
- Flush pulsed at cycle t0+10 of a DIV -> busy=0 at t0+11; no result_valid; result unchanged. A start at t0+5 during CALC is ignored.
- rst_n low mid-CALC, then released; new MUL 3x4 -> busy and result_valid reset to 0 at once; the following op returns 12 with normal latency.
